frq_meter: RTL
==============

Name: frq_meter

Overview:
- Downstream stage of the ROM-controlled frequency divider. Measures the divider's clk_out by counting its rising edges over a fixed gate window of the system clock.
- Reports the edge count, a one-cycle valid strobe and an overflow flag.
- Used on-chip to self-check each F_select setting, either one-shot or continuously.

Parameters:
- GATE_CYCLES, 1000, length of the gate window in clk cycles (>= 2).
- CNT_W, 16, width of the edge counter and of the count output.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- sig_in  input  1  signal under measurement (divider clk_out); asynchronous to clk.
- start  input  1  one-cycle request to begin a measurement.
- cont  input  1  1 = re-arm automatically after each result; sampled in DONE.
- busy  output  1  high in CLEAR, MEASURE and DONE.
- count  output  CNT_W  edge count of the last completed window; held until the next result.
- count_valid  output  1  one-cycle strobe when count updates.
- overflow  output  1  edge counter saturated during the last completed window; updates with count.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, busy=0, count=0, count_valid=0, overflow=0.
  - Synchronizer flops, edge-detect flop, gate counter and edge counter = 0.
- Input capture:
  - sig_in passes a 2-FF synchronizer, then a delay flop.
  - edge_pulse = sync_q & ~delay_q.
  - A sig_in rising edge meeting setup produces edge_pulse exactly 2 clk edges later, high for 1 cycle.
  - sig_in high for at least 1 clk period and low for at least 1 clk period is required for every edge to be seen. Faster inputs are undefined but must not hang the FSM.
- FSM states: IDLE, CLEAR, MEASURE, DONE.
- IDLE:
  - busy=0.
  - start=1 -> CLEAR.
- CLEAR (1 cycle):
  - Edge counter <= 0, gate counter <= 0, overflow accumulator <= 0.
  - Always -> MEASURE.
- MEASURE (exactly GATE_CYCLES cycles):
  - Gate counter increments each cycle.
  - Each cycle with edge_pulse=1 increments the edge counter.
  - At CNT_W all-ones the counter saturates instead of wrapping and the accumulator sets.
  - An edge_pulse in the last MEASURE cycle is counted.
  - Gate counter = GATE_CYCLES-1 -> DONE.
- DONE (1 cycle):
  - count <= edge counter, overflow <= accumulator, count_valid=1.
  - cont=1 -> CLEAR, else -> IDLE.
- Window accounting:
  - One result every GATE_CYCLES+2 cycles in continuous mode.
  - Edges whose edge_pulse falls in CLEAR or DONE are not counted.
- start handling:
  - start while busy=1 is ignored and does not restart the window.
  - start and cont asserted together in IDLE start a continuous run.
- Stopping continuous mode:
  - Deassert cont; the run stops after the current window's DONE.
  - cont is only sampled in DONE.
- Reset mid-measurement:
  - Aborts immediately, no count_valid.
  - Outputs return to reset values, including clearing the held count.
- Widths:
  - Gate counter width = clog2(GATE_CYCLES).
  - All counting is unsigned; no wrap anywhere.

Test Plan:
1. GATE_CYCLES=100, CNT_W=16; sig_in period 10 clk (5 high/5 low), first rising edge 3 cycles after start; pulse start -> count_valid exactly 102 cycles after start's cycle, count=10, overflow=0, busy low the next cycle.
2. sig_in held at 0, start -> count=0, count_valid once. sig_in held at 1 from before start -> count=0.
3. CNT_W=4, GATE_CYCLES=100, sig_in period 2 clk -> count=15 (saturated), overflow=1. Next one-shot with sig_in static -> count=0, overflow=0.
4. cont=1 with start, period 10 stimulus -> count_valid every 102 cycles with count=10 each time. Drop cont during the 3rd window -> exactly 3 results, then IDLE.
5. Assert start repeatedly while busy -> window length unchanged, single result. reset_n low at MEASURE cycle 50 -> busy=0, count=0, no count_valid; a fresh start then measures normally.
6. sig_in rising edge timed so edge_pulse lands in the last MEASURE cycle -> counted. Edge timed so edge_pulse lands in DONE -> not counted, and not counted in the next window either.

Source files
------------

// File: rtl/frq_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in over a fixed gate
// window of clk cycles and reports the count with a valid strobe and overflow flag.
module frq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow
);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             sync1_reg;
    logic             sync2_reg;
    logic             delay_reg;
    logic             edge_pulse;
    logic [GW-1:0]    gate_reg;
    logic [CNT_W-1:0] edge_cnt_reg;
    logic [CNT_W-1:0] edge_cnt_next;
    logic             ovf_acc_reg;
    logic             ovf_acc_next;
    logic [CNT_W-1:0] count_reg;
    logic             ovf_reg;

    // Two-flop synchronizer followed by a delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            delay_reg <= 1'b0;
        end else begin
            sync1_reg <= sig_in;
            sync2_reg <= sync1_reg;
            delay_reg <= sync2_reg;
        end
    end

    assign edge_pulse = sync2_reg & ~delay_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = MEASURE;
            MEASURE: if (gate_reg == GATE_LAST) state_next = DONE;
            DONE:    state_next = cont ? CLEAR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_reg != IDLE);
        count_valid = (state_reg == DONE);
    end

    // Saturating edge counter; an edge arriving at all-ones marks the window as overflowed.
    always_comb begin
        edge_cnt_next = edge_cnt_reg;
        ovf_acc_next  = ovf_acc_reg;
        if (edge_pulse) begin
            if (edge_cnt_reg == CNT_MAX) begin
                ovf_acc_next = 1'b1;
            end else begin
                edge_cnt_next = edge_cnt_reg + CNT_W'(1);
            end
        end
    end

    // The result is latched on the last MEASURE edge so it is already stable while count_valid is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate_reg     <= '0;
            edge_cnt_reg <= '0;
            ovf_acc_reg  <= 1'b0;
            count_reg    <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    gate_reg     <= '0;
                    edge_cnt_reg <= '0;
                    ovf_acc_reg  <= 1'b0;
                end
                MEASURE: begin
                    edge_cnt_reg <= edge_cnt_next;
                    ovf_acc_reg  <= ovf_acc_next;
                    if (gate_reg == GATE_LAST) begin
                        count_reg <= edge_cnt_next;
                        ovf_reg   <= ovf_acc_next;
                    end else begin
                        gate_reg <= gate_reg + GW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count    = count_reg;
    assign overflow = ovf_reg;

endmodule
